// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between the icache and dcache sides.
// Dcache normally wins; a starvation counter forces icache in after MAX_DGRANT dcache completions.
module mem_arbiter #(
  parameter int MAX_DGRANT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [3:0] CMAX      = 4'(MAX_DGRANT);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       dreq, acc;

  assign dreq  = dREN | dWEN;
  assign acc   = (ramstate == RS_ACCESS);
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gnt      = 2'b00;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      IDLE: begin
        if (dreq && (cnt < CMAX || !iREN)) state_n = DGRANT;
        else if (iREN)                     state_n = IGRANT;
      end
      IGRANT: begin
        gnt     = 2'b01;
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) state_n = IDLE;
        else if (acc) begin
          iwait   = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      DGRANT: begin
        gnt      = 2'b10;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) state_n = IDLE;
        else if (acc) begin
          dwait   = 1'b0;
          state_n = IDLE;
          // count only completions that made a pending fetch wait
          if (!iREN)            cnt_n = '0;
          else if (cnt < CMAX)  cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, priority, write path, stalls, withdrawal, starvation.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  gnt;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  int n_chk = 0;
  int n_bad = 0;

  mem_arbiter #(.MAX_DGRANT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .gnt(gnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  logic [1:0] eg [8];

  initial begin
    eg = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = 32'h8C220004; ramstate = ACCESS;

    // reset state with a pending fetch and ACCESS on the bus
    smp();
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_ramren", 32'(ramREN), 32'd0);
    chk("rst_iwait",  32'(iwait),  32'd1);
    chk("rst_dwait",  32'(dwait),  32'd1);
    chk("rst_addr",   ramaddr,     32'd0);
    nRST = 1'b1;
    nxt(); smp();
    chk("i1_gnt",    32'(gnt),    32'd1);
    chk("i1_ramren", 32'(ramREN), 32'd1);
    chk("i1_addr",   ramaddr,     32'h40);
    chk("i1_iwait",  32'(iwait),  32'd0);
    chk("i1_iload",  iload,       32'h8C220004);
    chk("i1_dwait",  32'(dwait),  32'd1);
    nxt(); iREN = 1'b0;

    // simultaneous request: dcache first, then icache
    nxt(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramload = 32'h1234;
    smp();
    chk("sim_idle_gnt", 32'(gnt),    32'd0);
    chk("sim_idle_ren", 32'(ramREN), 32'd0);
    nxt(); smp();
    chk("sim_d_gnt",   32'(gnt),    32'd2);
    chk("sim_d_addr",  ramaddr,     32'h100);
    chk("sim_d_ren",   32'(ramREN), 32'd1);
    chk("sim_d_dwait", 32'(dwait),  32'd0);
    chk("sim_d_iwait", 32'(iwait),  32'd1);
    chk("sim_d_dload", dload,       32'h1234);
    nxt(); dREN = 1'b0;
    smp();
    chk("sim_gap_gnt", 32'(gnt), 32'd0);
    nxt(); smp();
    chk("sim_i_gnt",   32'(gnt),   32'd1);
    chk("sim_i_iwait", 32'(iwait), 32'd0);
    chk("sim_i_addr",  ramaddr,    32'h44);
    nxt(); iREN = 1'b0;

    // write wins over read; BUSY stalls, ERROR is not completion
    dWEN = 1'b1; dREN = 1'b1; dstore = 32'hDEADBEEF; daddr = 32'h200; ramstate = BUSY;
    nxt(); smp();
    chk("wr_wen",   32'(ramWEN), 32'd1);
    chk("wr_ren",   32'(ramREN), 32'd0);
    chk("wr_store", ramstore,    32'hDEADBEEF);
    chk("wr_addr",  ramaddr,     32'h200);
    chk("busy_dwait0", 32'(dwait), 32'd1);
    for (int i = 1; i < 5; i++) begin
      nxt(); smp();
      chk($sformatf("busy_dwait%0d", i), 32'(dwait), 32'd1);
      chk($sformatf("busy_gnt%0d", i),   32'(gnt),   32'd2);
    end
    nxt(); ramstate = ERROR;
    smp();
    chk("err_dwait", 32'(dwait), 32'd1);
    chk("err_gnt",   32'(gnt),   32'd2);
    nxt(); ramstate = ACCESS;
    smp();
    chk("acc_dwait", 32'(dwait), 32'd0);
    nxt(); dWEN = 1'b0; dREN = 1'b0;

    // starvation: two dcache completions, a withdrawal, then two more before fetch is forced
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h80; ramstate = ACCESS;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("st_pre_gnt%0d", i), 32'(gnt), (i % 2 == 1) ? 32'd2 : 32'd0);
      nxt();
    end
    ramstate = BUSY;
    nxt(); smp();
    chk("wd_gnt",   32'(gnt),    32'd2);
    chk("wd_ren",   32'(ramREN), 32'd1);
    dREN = 1'b0; #1;
    chk("wd_ren_drop", 32'(ramREN), 32'd0);
    chk("wd_dwait",    32'(dwait),  32'd1);
    nxt(); dREN = 1'b1; ramstate = ACCESS;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk($sformatf("st_gnt%0d", i),   32'(gnt),   32'(eg[i]));
      chk($sformatf("st_iwait%0d", i), 32'(iwait), (eg[i] == 2'd1) ? 32'd0 : 32'd1);
      chk($sformatf("st_dwait%0d", i), 32'(dwait), (eg[i] == 2'd2) ? 32'd0 : 32'd1);
      nxt();
    end

    // reset mid-IGRANT drops everything immediately
    dREN = 1'b0; ramstate = BUSY;
    nxt(); smp();
    chk("ri_gnt", 32'(gnt),    32'd1);
    chk("ri_ren", 32'(ramREN), 32'd1);
    nRST = 1'b0; #1;
    chk("ri_rst_gnt",   32'(gnt),    32'd0);
    chk("ri_rst_ren",   32'(ramREN), 32'd0);
    chk("ri_rst_iwait", 32'(iwait),  32'd1);
    nxt(); nRST = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared RAM port between instruction-fetch requests (icache side) and data requests (dcache side) of the pipelined CPU.
- A registered FSM grants one requester at a time and holds the grant until the RAM completes or the requester withdraws.
- Releases the requester's wait when the RAM completes.
- Dcache normally has priority; a starvation counter forces an icache grant after MAX_DGRANT consecutive dcache completions while fetch is pending.
- Wait/hit outputs feed the hazard unit's stall decisions.

Parameters:
- MAX_DGRANT, 4: consecutive dcache completions allowed while iREN is high before icache is forced in. Legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction read request.
- iaddr  input  32  instruction address (word_t).
- iwait  output  1  instruction request not yet satisfied.
- iload  output  32  instruction read data.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  32  data address.
- dstore  input  32  data write value.
- dwait  output  1  data request not yet satisfied.
- dload  output  32  data read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- gnt  output  2  current grant: 00 none, 01 icache, 10 dcache.

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- FSM states: IDLE, IGRANT, DGRANT.
- Reset values: state = IDLE, starve counter = 0.
- Reset output values: gnt=00, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Reset asserted mid-transaction aborts immediately; RAM enables drop asynchronously.
- dreq = dREN | dWEN.
- IDLE transitions:
  - dreq & (cnt < MAX_DGRANT | !iREN) -> DGRANT.
  - else iREN -> IGRANT.
  - else stay IDLE.
- Arbitration latency: one cycle. The request is sampled in IDLE; RAM enables assert in the following cycle.
- IGRANT outputs (combinational from state and inputs):
  - ramREN = iREN, ramWEN = 0, ramaddr = iaddr.
- DGRANT outputs:
  - ramWEN = dWEN, ramREN = dREN & !dWEN (write wins when both are set).
  - ramaddr = daddr, ramstore = dstore.
- IDLE outputs: all RAM enables 0; ramaddr and ramstore = 0.
- Completion is the granted state with ramstate == ACCESS and the request still asserted:
  - The granted side's wait = 0 for that single cycle; next state = IDLE.
  - The other side's wait stays 1.
- BUSY, FREE and ERROR in a grant state: wait stays 1 and the state holds. ERROR is never treated as completion.
- Withdrawal: if the granted request deasserts before completion, RAM enables drop the same cycle and the next state is IDLE. The counter is unchanged.
- iload = ramload and dload = ramload (pass-through); valid only in the cycle the respective wait is 0.
- Starve counter (4 bits, saturating at MAX_DGRANT):
  - On dcache completion with iREN=1: cnt + 1.
  - On dcache completion with iREN=0: cnt cleared to 0.
  - On icache completion: cnt cleared to 0.
- Forcing icache: with cnt == MAX_DGRANT and both requesting in IDLE, IGRANT is taken.
- No back-to-back grants: at least one IDLE cycle separates transactions. Minimum transaction is two cycles (IDLE + grant with immediate ACCESS).
- Simultaneous requests in IDLE with cnt < MAX_DGRANT: dcache wins. iwait stays 1 throughout.
- gnt reflects state: IDLE=00, IGRANT=01, DGRANT=10.

Test Plan:
- Reset with iREN=1 and ramstate=ACCESS -> gnt=00, ramREN=0, iwait=1 during reset. The first edge after release gives gnt=01, ramREN=1, ramaddr=iaddr, iwait=0 that cycle, iload=ramload (e.g. 0x8C220004).
- iREN=1 and dREN=1 together, daddr=0x100, ramstate=ACCESS -> DGRANT first, dwait=0 one cycle; then IDLE, then IGRANT, iwait=0.
- dWEN=1 and dREN=1, dstore=0xDEADBEEF, daddr=0x200 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, ramaddr=0x200.
- dreq held high continuously and iREN high, MAX_DGRANT=4, ramstate=ACCESS -> exactly 4 dcache completions, then one icache completion, then the counter is 0 and dcache resumes.
- ramstate=BUSY for 5 cycles in DGRANT, then ACCESS -> dwait=1 for those 5 cycles, dwait=0 on the ACCESS cycle. ERROR injected instead of ACCESS -> dwait stays 1.
- dREN dropped while DGRANT and BUSY -> ramREN=0 the same cycle, gnt=00 next cycle, counter unchanged. nRST asserted mid-IGRANT -> gnt=00 and ramREN=0 immediately.
